vga_sync_generator: RTL and testbench
=====================================

// Module: vga_sync_generator
// PURPOSE
//  Raster timing source for the VGA path. Produces the h_count/v_count pixel coordinates consumed by
//  color_generation, a display-enable flag, and VGA_HS/VGA_VS sync pulses. Sync pulses are delayed
//  to line up with the pixel pipeline latency downstream. Also emits one-cycle frame/line ticks that
//  pace game logic (player/car movement) once per frame.
// PARAMETERS
//  H_DISPLAY   640  visible pixels per line
//  H_FRONT     16   horizontal front porch (pixels)
//  H_SYNC      96   horizontal sync width (pixels)
//  H_BACK      48   horizontal back porch (pixels)
//  V_DISPLAY   480  visible lines per frame
//  V_FRONT     10   vertical front porch (lines)
//  V_SYNC      2    vertical sync width (lines)
//  V_BACK      33   vertical back porch (lines)
//  CLK_DIV     1    CLK cycles per pixel (1..4); pixel enable fires every CLK_DIV cycles
//  SYNC_POL    0    sync active level (0 = active-low)
//  PIPE_DELAY  2    CLK-cycle delay on VGA_HS/VGA_VS/display_en_d (0..7), matches color pipeline
// PORTS
//  CLK           in   1   system clock (25 MHz)
//  RST_N         in   1   asynchronous reset, active-low
//  h_count       out  10  current pixel column, 0..H_TOTAL-1
//  v_count       out  10  current line, 0..V_TOTAL-1
//  pix_en        out  1   high for the CLK cycle in which the counters advance
//  display_en    out  1   h_count<H_DISPLAY && v_count<V_DISPLAY (undelayed)
//  display_en_d  out  1   display_en delayed PIPE_DELAY cycles
//  VGA_HS        out  1   horizontal sync, delayed PIPE_DELAY cycles
//  VGA_VS        out  1   vertical sync, delayed PIPE_DELAY cycles
//  line_tick     out  1   one-CLK pulse when h_count wraps to 0
//  frame_tick    out  1   one-CLK pulse when (h_count,v_count) wraps to (0,0)
// BEHAVIOUR
//  - H_TOTAL = sum of H_* (800), V_TOTAL = sum of V_* (525); both must be <= 1024 (elaboration check).
//  - Reset (RST_N low, async): div counter, h_count, v_count = 0; pix_en, line_tick, frame_tick,
//    display_en_d = 0; VGA_HS/VGA_VS = inactive level (~SYNC_POL); whole delay line cleared to same.
//  - Divider: div_cnt counts 0..CLK_DIV-1; pix_en = (div_cnt == CLK_DIV-1). CLK_DIV=1 -> pix_en constant 1
//    after reset release. First pix_en occurs CLK_DIV cycles after RST_N rises.
//  - Horizontal FSM H_ACT -> H_FP -> H_SYNC -> H_BP -> H_ACT, transitions only on pix_en at column
//    boundaries 640/656/752/0. h_count increments on pix_en; at H_TOTAL-1 wraps to 0.
//  - Vertical FSM V_ACT -> V_FP -> V_SYNC -> V_BP, same scheme on lines 480/490/492/0; v_count advances
//    only on an h wrap; at V_TOTAL-1 with h wrap, both wrap to 0.
//  - hs_raw active while H state = H_SYNC (cols 656..751); vs_raw active while V state = V_SYNC (lines
//    490..491). Raw syncs registered, then pass through PIPE_DELAY-stage shift register clocked every CLK
//    (not gated by pix_en). PIPE_DELAY=0 -> outputs equal the registered raw values.
//  - line_tick/frame_tick registered: high exactly in the CLK cycle in which counters show the wrapped
//    value; never asserted by reset release (counters start at 0,0 without a wrap).
//  - Counters never exceed H_TOTAL-1 / V_TOTAL-1; no other wrap points.
//  - Reset mid-frame: immediate return to reset state; next frame starts from (0,0), first frame_tick
//    only after one full frame (H_TOTAL*V_TOTAL pixels).
// TESTING
//  1. Defaults, release RST_N: h_count=0..799 one per CLK, at 799->0 line_tick=1, v_count 0->1.
//  2. HS check: raw col 656 reached at cycle N -> VGA_HS falls at N+1+2; rises 96 cycles later; high otherwise.
//  3. VS check: VGA_VS low exactly for lines 490..491 (1600 CLKs) with same 3-cycle offset; frame_tick
//     period = 420000 CLKs; display_en high 640 cycles/line on lines 0..479 only.
//  4. CLK_DIV=2: pix_en every other cycle, counters hold between; frame_tick period 840000 CLKs.
//  5. Assert RST_N at (h=300,v=200) for 3 cycles: all outputs to reset values mid-cycle (async);
//     HS/VS=1; no frame_tick for 420000 CLKs after release.
//  6. SYNC_POL=1, PIPE_DELAY=0: VGA_HS high cols 656..751 with 1-cycle offset, low otherwise, reset level 0.

Source files
------------

// File: rtl/vga_sync_generator.sv
// Raster timing source for the VGA path.
// A free-running pixel-enable divider paces horizontal and vertical counters.
// Two small state machines (one per axis) track the active, porch and sync regions.
// Each axis's sync level is registered once and then passed through an alignment
// shift register, so the pulses line up with the downstream colour pipeline.
// One-cycle line and frame ticks are also produced to pace the game logic.
module vga_sync_generator #(
  parameter int   H_DISPLAY  = 640,
  parameter int   H_FRONT    = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BACK     = 48,
  parameter int   V_DISPLAY  = 480,
  parameter int   V_FRONT    = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BACK     = 33,
  parameter int   CLK_DIV    = 1,
  parameter logic SYNC_POL   = 1'b0,
  parameter int   PIPE_DELAY = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       pix_en,
  output logic       display_en,
  output logic       display_en_d,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       line_tick,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // Last column/line of each region; a region is left when the counter advances past it.
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_ACT_END  = 10'(H_DISPLAY - 1);
  localparam logic [9:0] H_FP_END   = 10'(H_DISPLAY + H_FRONT - 1);
  localparam logic [9:0] H_SYNC_END = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_ACT_END  = 10'(V_DISPLAY - 1);
  localparam logic [9:0] V_FP_END   = 10'(V_DISPLAY + V_FRONT - 1);
  localparam logic [9:0] V_SYNC_END = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic [1:0] DIV_LAST   = 2'(CLK_DIV - 1);

  // The counters are 10 bits wide and the divider is 2 bits wide, so reject anything larger.
  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1 || CLK_DIV > 4 ||
        PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_param_check
      $error("vga_sync_generator: raster totals must be <= 1024, CLK_DIV 1..4, PIPE_DELAY 0..7");
    end
  endgenerate

  typedef enum logic [1:0] {
    H_ST_ACT  = 2'd0,
    H_ST_FP   = 2'd1,
    H_ST_SYNC = 2'd2,
    H_ST_BP   = 2'd3
  } h_state_e;

  typedef enum logic [1:0] {
    V_ST_ACT  = 2'd0,
    V_ST_FP   = 2'd1,
    V_ST_SYNC = 2'd2,
    V_ST_BP   = 2'd3
  } v_state_e;

  logic [1:0] div_cnt_q, div_cnt_d;
  logic       pix_en_q, pix_en_d;
  logic [9:0] h_count_q, h_count_d;
  logic [9:0] v_count_q, v_count_d;
  h_state_e   h_state_q, h_state_d;
  v_state_e   v_state_q, v_state_d;
  logic       line_tick_q, line_tick_d;
  logic       frame_tick_q, frame_tick_d;
  logic       disp_en_q, disp_en_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       h_wrap_s;
  logic       f_wrap_s;

  // A line wraps on the pixel enable at the last column; a frame also needs the last line.
  assign h_wrap_s = pix_en_q && (h_count_q == H_LAST);
  assign f_wrap_s = h_wrap_s && (v_count_q == V_LAST);

  // Pixel-enable divider: pix_en is raised for one cycle in every CLK_DIV.
  always_comb begin
    div_cnt_d = div_cnt_q;
    pix_en_d  = 1'b0;
    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = 2'd0;
      pix_en_d  = 1'b1;
    end else begin
      div_cnt_d = div_cnt_q + 2'd1;
      pix_en_d  = 1'b0;
    end
  end

  // Raster counters: the column advances on pix_en, and the line advances on a column wrap.
  always_comb begin
    h_count_d = h_count_q;
    v_count_d = v_count_q;
    if (h_wrap_s) begin
      h_count_d = 10'd0;
      if (v_count_q == V_LAST) begin
        v_count_d = 10'd0;
      end else begin
        v_count_d = v_count_q + 10'd1;
      end
    end else if (pix_en_q) begin
      h_count_d = h_count_q + 10'd1;
    end else begin
      h_count_d = h_count_q;
    end
  end

  // Horizontal region tracker: moves on the pixel enable at each region's last column.
  always_comb begin
    h_state_d = h_state_q;
    case (h_state_q)
      H_ST_ACT: begin
        if (pix_en_q && (h_count_q == H_ACT_END)) h_state_d = H_ST_FP;
        else                                      h_state_d = H_ST_ACT;
      end
      H_ST_FP: begin
        if (pix_en_q && (h_count_q == H_FP_END)) h_state_d = H_ST_SYNC;
        else                                     h_state_d = H_ST_FP;
      end
      H_ST_SYNC: begin
        if (pix_en_q && (h_count_q == H_SYNC_END)) h_state_d = H_ST_BP;
        else                                       h_state_d = H_ST_SYNC;
      end
      H_ST_BP: begin
        if (h_wrap_s) h_state_d = H_ST_ACT;
        else          h_state_d = H_ST_BP;
      end
      default: h_state_d = H_ST_ACT;
    endcase
  end

  // Vertical region tracker: moves only on a line wrap at each region's last line.
  always_comb begin
    v_state_d = v_state_q;
    case (v_state_q)
      V_ST_ACT: begin
        if (h_wrap_s && (v_count_q == V_ACT_END)) v_state_d = V_ST_FP;
        else                                      v_state_d = V_ST_ACT;
      end
      V_ST_FP: begin
        if (h_wrap_s && (v_count_q == V_FP_END)) v_state_d = V_ST_SYNC;
        else                                     v_state_d = V_ST_FP;
      end
      V_ST_SYNC: begin
        if (h_wrap_s && (v_count_q == V_SYNC_END)) v_state_d = V_ST_BP;
        else                                       v_state_d = V_ST_SYNC;
      end
      V_ST_BP: begin
        if (f_wrap_s) v_state_d = V_ST_ACT;
        else          v_state_d = V_ST_BP;
      end
      default: v_state_d = V_ST_ACT;
    endcase
  end

  // Output next state: the ticks and display enable align with the new counter values.
  // The raw sync levels are sampled from the current region, which adds one cycle of latency.
  always_comb begin
    line_tick_d  = h_wrap_s;
    frame_tick_d = f_wrap_s;
    disp_en_d    = (h_state_d == H_ST_ACT) && (v_state_d == V_ST_ACT);
    hs_d         = (h_state_q == H_ST_SYNC) ? SYNC_POL : ~SYNC_POL;
    vs_d         = (v_state_q == V_ST_SYNC) ? SYNC_POL : ~SYNC_POL;
  end

  // Core state registers. (0,0) is a visible pixel, so the display enable resets high.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_cnt_q    <= 2'd0;
      pix_en_q     <= 1'b0;
      h_count_q    <= 10'd0;
      v_count_q    <= 10'd0;
      h_state_q    <= H_ST_ACT;
      v_state_q    <= V_ST_ACT;
      line_tick_q  <= 1'b0;
      frame_tick_q <= 1'b0;
      disp_en_q    <= 1'b1;
      hs_q         <= ~SYNC_POL;
      vs_q         <= ~SYNC_POL;
    end else begin
      div_cnt_q    <= div_cnt_d;
      pix_en_q     <= pix_en_d;
      h_count_q    <= h_count_d;
      v_count_q    <= v_count_d;
      h_state_q    <= h_state_d;
      v_state_q    <= v_state_d;
      line_tick_q  <= line_tick_d;
      frame_tick_q <= frame_tick_d;
      disp_en_q    <= disp_en_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
    end
  end

  // The alignment delay runs on every CLK, independent of the pixel enable.
  generate
    if (PIPE_DELAY == 0) begin : g_no_delay
      assign VGA_HS       = hs_q;
      assign VGA_VS       = vs_q;
      assign display_en_d = disp_en_q;
    end else begin : g_delay
      logic [PIPE_DELAY-1:0] hs_pipe_q;
      logic [PIPE_DELAY-1:0] vs_pipe_q;
      logic [PIPE_DELAY-1:0] de_pipe_q;

      // Shift registers that line the syncs and the enable up with the colour pipeline.
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          hs_pipe_q <= {PIPE_DELAY{~SYNC_POL}};
          vs_pipe_q <= {PIPE_DELAY{~SYNC_POL}};
          de_pipe_q <= '0;
        end else begin
          hs_pipe_q[0] <= hs_q;
          vs_pipe_q[0] <= vs_q;
          de_pipe_q[0] <= disp_en_q;
          for (int i = 1; i < PIPE_DELAY; i++) begin
            hs_pipe_q[i] <= hs_pipe_q[i-1];
            vs_pipe_q[i] <= vs_pipe_q[i-1];
            de_pipe_q[i] <= de_pipe_q[i-1];
          end
        end
      end

      assign VGA_HS       = hs_pipe_q[PIPE_DELAY-1];
      assign VGA_VS       = vs_pipe_q[PIPE_DELAY-1];
      assign display_en_d = de_pipe_q[PIPE_DELAY-1];
    end
  endgenerate

  assign h_count    = h_count_q;
  assign v_count    = v_count_q;
  assign pix_en     = pix_en_q;
  assign display_en = disp_en_q;
  assign line_tick  = line_tick_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_sync_generator.sv
// Bench for vga_sync_generator.
// Three instances are driven from one clock and one reset:
//   u0 - default 640x480 timing,
//   u1 - small raster with CLK_DIV=2 and PIPE_DELAY=3,
//   u2 - small raster with active-high syncs and no alignment delay.
// A reference raster model per instance pushes expected delayed outputs into
// history queues; these are popped and compared every cycle on the falling edge.
module tb_vga_sync_generator;

  localparam int N = 3;
  localparam int C_HD  [N] = '{640, 20, 20};
  localparam int C_HF  [N] = '{16, 4, 4};
  localparam int C_HS  [N] = '{96, 6, 6};
  localparam int C_HB  [N] = '{48, 5, 5};
  localparam int C_VD  [N] = '{480, 6, 6};
  localparam int C_VF  [N] = '{10, 2, 2};
  localparam int C_VS  [N] = '{2, 2, 2};
  localparam int C_VB  [N] = '{33, 3, 3};
  localparam int C_DIV [N] = '{1, 2, 1};
  localparam bit C_POL [N] = '{1'b0, 1'b0, 1'b1};
  localparam int C_PD  [N] = '{2, 3, 0};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [9:0] hc [N];
  logic [9:0] vc [N];
  logic       pix [N];
  logic       de [N];
  logic       ded [N];
  logic       hs [N];
  logic       vs [N];
  logic       lt [N];
  logic       ft [N];

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  // Reference model state, as seen after the most recent rising edge.
  int         m_h [N];
  int         m_v [N];
  int         m_div [N];
  logic       m_pix [N];
  logic       m_lt [N];
  logic       m_ft [N];
  logic [1:0] m_sync [N];
  logic       m_ded [N];
  logic [1:0] sync_q [N][$];
  logic       de_q [N][$];

  int hs_run [N];
  int vs_run [N];
  int ft_last [N];
  int lt_last [N];
  int ft_seen [N];

  always #5 clk = ~clk;

  vga_sync_generator u_dut0 (
    .CLK(clk), .RST_N(rst_n), .h_count(hc[0]), .v_count(vc[0]), .pix_en(pix[0]),
    .display_en(de[0]), .display_en_d(ded[0]), .VGA_HS(hs[0]), .VGA_VS(vs[0]),
    .line_tick(lt[0]), .frame_tick(ft[0])
  );

  vga_sync_generator #(
    .H_DISPLAY(20), .H_FRONT(4), .H_SYNC(6), .H_BACK(5),
    .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .CLK_DIV(2), .SYNC_POL(1'b0), .PIPE_DELAY(3)
  ) u_dut1 (
    .CLK(clk), .RST_N(rst_n), .h_count(hc[1]), .v_count(vc[1]), .pix_en(pix[1]),
    .display_en(de[1]), .display_en_d(ded[1]), .VGA_HS(hs[1]), .VGA_VS(vs[1]),
    .line_tick(lt[1]), .frame_tick(ft[1])
  );

  vga_sync_generator #(
    .H_DISPLAY(20), .H_FRONT(4), .H_SYNC(6), .H_BACK(5),
    .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .CLK_DIV(1), .SYNC_POL(1'b1), .PIPE_DELAY(0)
  ) u_dut2 (
    .CLK(clk), .RST_N(rst_n), .h_count(hc[2]), .v_count(vc[2]), .pix_en(pix[2]),
    .display_en(de[2]), .display_en_d(ded[2]), .VGA_HS(hs[2]), .VGA_VS(vs[2]),
    .line_tick(lt[2]), .frame_tick(ft[2])
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int h_tot(input int k);
    return C_HD[k] + C_HF[k] + C_HS[k] + C_HB[k];
  endfunction

  function automatic int v_tot(input int k);
    return C_VD[k] + C_VF[k] + C_VS[k] + C_VB[k];
  endfunction

  // Raw sync levels {hs, vs} for a raster position, derived from the column and line ranges.
  function automatic logic [1:0] raw_sync(input int k, input int h, input int v);
    logic hs_a;
    logic vs_a;
    hs_a = (h >= C_HD[k] + C_HF[k]) && (h < C_HD[k] + C_HF[k] + C_HS[k]);
    vs_a = (v >= C_VD[k] + C_VF[k]) && (v < C_VD[k] + C_VF[k] + C_VS[k]);
    return {(hs_a ? C_POL[k] : ~C_POL[k]), (vs_a ? C_POL[k] : ~C_POL[k])};
  endfunction

  function automatic logic visible(input int k, input int h, input int v);
    return (h < C_HD[k]) && (v < C_VD[k]);
  endfunction

  // History queues hold (delay) cleared entries followed by the value for the current cycle.
  task automatic model_reset(input int k);
    m_h[k]   = 0;
    m_v[k]   = 0;
    m_div[k] = 0;
    m_pix[k] = 1'b0;
    m_lt[k]  = 1'b0;
    m_ft[k]  = 1'b0;
    sync_q[k].delete();
    de_q[k].delete();
    for (int i = 0; i < C_PD[k] + 1; i++) sync_q[k].push_back({~C_POL[k], ~C_POL[k]});
    for (int i = 0; i < C_PD[k]; i++) de_q[k].push_back(1'b0);
    sync_q[k].push_back(raw_sync(k, 0, 0));
    de_q[k].push_back(visible(k, 0, 0));
    m_sync[k] = sync_q[k][0];
    m_ded[k]  = de_q[k][0];
  endtask

  task automatic model_step(input int k);
    logic adv;
    adv      = m_pix[k];
    m_lt[k]  = adv && (m_h[k] == h_tot(k) - 1);
    m_ft[k]  = m_lt[k] && (m_v[k] == v_tot(k) - 1);
    if (adv) begin
      if (m_lt[k]) begin
        m_h[k] = 0;
        m_v[k] = (m_v[k] == v_tot(k) - 1) ? 0 : m_v[k] + 1;
      end else begin
        m_h[k] = m_h[k] + 1;
      end
    end
    m_pix[k] = (m_div[k] == C_DIV[k] - 1);
    m_div[k] = m_pix[k] ? 0 : m_div[k] + 1;
    sync_q[k].push_back(raw_sync(k, m_h[k], m_v[k]));
    de_q[k].push_back(visible(k, m_h[k], m_v[k]));
    void'(sync_q[k].pop_front());
    void'(de_q[k].pop_front());
    m_sync[k] = sync_q[k][0];
    m_ded[k]  = de_q[k][0];
  endtask

  task automatic compare_all();
    for (int k = 0; k < N; k++) begin
      if (!rst_n) begin
        check_value($sformatf("u%0d_rst_cnt", k), 32'({hc[k], vc[k]}), 32'd0);
        check_value($sformatf("u%0d_rst_flags", k), 32'({pix[k], lt[k], ft[k], de[k]}), 32'h1);
        check_value($sformatf("u%0d_rst_sync", k), 32'({hs[k], vs[k]}), 32'({~C_POL[k], ~C_POL[k]}));
        if (C_PD[k] > 0) check_value($sformatf("u%0d_rst_de_d", k), 32'(ded[k]), 32'd0);
      end else begin
        check_value($sformatf("u%0d_cnt", k), 32'({hc[k], vc[k]}),
                    32'({m_h[k][9:0], m_v[k][9:0]}));
        check_value($sformatf("u%0d_flags", k), 32'({pix[k], lt[k], ft[k], de[k]}),
                    32'({m_pix[k], m_lt[k], m_ft[k], visible(k, m_h[k], m_v[k])}));
        check_value($sformatf("u%0d_sync_de_d", k), 32'({hs[k], vs[k], ded[k]}),
                    32'({m_sync[k], m_ded[k]}));
      end
    end
  endtask

  // Advance the reference model on every rising edge.
  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < N; k++) begin
      if (!rst_n) model_reset(k);
      else        model_step(k);
    end
  end

  // Compare on the falling edge, then check pulse widths and tick periods.
  always @(negedge clk) begin
    compare_all();
    for (int k = 0; k < N; k++) begin
      if (!rst_n) begin
        hs_run[k]  = 0;
        vs_run[k]  = 0;
        ft_last[k] = -1;
        lt_last[k] = -1;
      end else begin
        if (hs[k] == C_POL[k]) begin
          hs_run[k]++;
        end else begin
          if (hs_run[k] > 0) check_value($sformatf("u%0d_hs_width", k), 32'(hs_run[k]), 32'(C_HS[k] * C_DIV[k]));
          hs_run[k] = 0;
        end
        if (vs[k] == C_POL[k]) begin
          vs_run[k]++;
        end else begin
          if (vs_run[k] > 0)
            check_value($sformatf("u%0d_vs_width", k), 32'(vs_run[k]), 32'(C_VS[k] * h_tot(k) * C_DIV[k]));
          vs_run[k] = 0;
        end
        if (lt[k]) begin
          if (lt_last[k] >= 0) check_value($sformatf("u%0d_line_period", k), 32'(cyc - lt_last[k]), 32'(h_tot(k) * C_DIV[k]));
          lt_last[k] = cyc;
        end
        if (ft[k]) begin
          if (ft_last[k] >= 0)
            check_value($sformatf("u%0d_frame_period", k), 32'(cyc - ft_last[k]), 32'(h_tot(k) * v_tot(k) * C_DIV[k]));
          ft_last[k] = cyc;
          ft_seen[k]++;
        end
      end
    end
  end

  initial begin
    int waited;
    int n;
    bit found;
    for (int k = 0; k < N; k++) ft_seen[k] = 0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2000) @(posedge clk);

    // Bring the default raster to column 300 and drop reset between clock edges.
    @(negedge clk);
    waited = 0;
    while (hc[0] != 10'd300 && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    check_value("u0_reach_col300", 32'(hc[0]), 32'd300);
    #2 rst_n = 1'b0;
    #1 compare_all();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // After release, u1 needs 2 cycles for its first pix_en and then 455 pixels of 2 cycles each.
    n = 0;
    found = 1'b0;
    while (!found && n < 2000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (ft[1]) found = 1'b1;
    end
    check_value("u1_first_frame_tick", 32'(n), 32'd911);

    repeat (1500) @(posedge clk);
    @(negedge clk);
    check_value("u2_frames_seen", 32'(ft_seen[2] >= 5), 32'd1);
    check_value("u1_frames_seen", 32'(ft_seen[1] >= 3), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
